regfile_scoreboard: RTL and testbench

Parametrised register file for the MIPS-style CPU core, for the decode stage.
- Provides NUM_RD combinational read ports with write-through bypass.
- Provides one pipeline write-back port and one external I/O write port that targets a fixed register.
- Includes a per-register busy scoreboard, so decode can detect load-use hazards and stall.
- Holds a last-committed-write capture register for the memory/IO datapath.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/regfile_read_port.sv | 48 ++++
 rtl/regfile_scoreboard.sv | 108 ++++++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: datapath widths, architectural register names
// and helpers for the packed multi-port address/data vectors.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_T9   = 25;
  localparam int REG_RA   = 31;

  // Two-port packing at the default widths; port 0 sits in the low field.
  function automatic logic [2*CPU_ADDR_W-1:0] pack_addr2(input logic [CPU_ADDR_W-1:0] a0,
                                                         input logic [CPU_ADDR_W-1:0] a1);
    return {a1, a0};
  endfunction

  function automatic logic [CPU_DATA_W-1:0] unpack_data2(input logic [2*CPU_DATA_W-1:0] v,
                                                         input int unsigned idx);
    return v[idx*CPU_DATA_W +: CPU_DATA_W];
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: zero-register forcing, ext/wb write-through
// bypass, and scoreboard busy qualification.
module regfile_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int EXT_REG  = REG_T9,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              busy_bit,
  input  logic              ext_en,
  input  logic [DATA_W-1:0] ext_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_busy
);

  localparam logic [ADDR_W-1:0] EXT_IDX  = ADDR_W'(EXT_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic is_zero;
  logic wb_hit;

  assign is_zero = ZERO_REG && (rd_addr == ZERO_IDX);
  assign wb_hit  = wb_en && (wb_addr == rd_addr);

  // A write-back in flight this cycle both supplies the data and retires the hazard.
  always_comb begin
    rd_data = stored_data;
    rd_busy = busy_bit && !wb_hit;
    if (is_zero) begin
      rd_data = {DATA_W{1'b0}};
      rd_busy = 1'b0;
    end else if (ext_en && (rd_addr == EXT_IDX)) begin
      rd_data = ext_data;
    end else if (wb_hit) begin
      rd_data = wb_data;
    end else begin
      rd_data = stored_data;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file: storage, write-back and external write ports,
// per-register busy scoreboard and last-committed-write capture.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int EXT_REG  = REG_T9,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     ext_en,
  input  logic [DATA_W-1:0]        ext_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [DATA_W-1:0]        last_wr
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] EXT_IDX  = ADDR_W'(EXT_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA_W-1:0] last_wr_q;
  logic [DATA_W-1:0] last_wr_d;

  logic wb_ok;
  logic ext_ok;
  logic issue_ok;

  assign wb_ok    = wb_en && !(ZERO_REG && (wb_addr == ZERO_IDX));
  assign ext_ok   = ext_en && !(ZERO_REG && (EXT_IDX == ZERO_IDX));
  assign issue_ok = issue_en && !(ZERO_REG && (issue_addr == ZERO_IDX));

  // Ordering encodes priority: ext overrides wb data, a new issue overrides the wb clear.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    last_wr_d = last_wr_q;
    if (reset) begin
      regs_d    = '{default: {DATA_W{1'b0}}};
      busy_d    = {DEPTH{1'b0}};
      last_wr_d = {DATA_W{1'b0}};
    end else begin
      if (wb_ok) begin
        regs_d[wb_addr] = wb_data;
        busy_d[wb_addr] = 1'b0;
        last_wr_d       = wb_data;
      end else begin
        last_wr_d = last_wr_q;
      end
      if (ext_ok) begin
        regs_d[EXT_IDX] = ext_data;
      end else begin
        regs_d[EXT_IDX] = regs_d[EXT_IDX];
      end
      if (issue_ok) begin
        busy_d[issue_addr] = 1'b1;
      end else begin
        busy_d[issue_addr] = busy_d[issue_addr];
      end
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clock) begin
    regs_q    <= regs_d;
    busy_q    <= busy_d;
    last_wr_q <= last_wr_d;
  end

  assign last_wr = last_wr_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .EXT_REG (EXT_REG),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rd_addr    (addr_s),
      .stored_data(regs_q[addr_s]),
      .busy_bit   (busy_q[addr_s]),
      .ext_en     (ext_en),
      .ext_data   (ext_data),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rd_data    (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy    (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: behavioural model checked every cycle plus
// hand-computed expectations along the directed sequence.
module tb_regfile_scoreboard;
  import cpu_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic            ext_en;
  logic [DW-1:0]   ext_data;
  logic            issue_en;
  logic [AW-1:0]   issue_addr;
  logic [DW-1:0]   last_wr;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] m_regs [DEPTH];
  logic          m_busy [DEPTH];
  logic [DW-1:0] m_last;
  bit            model_valid = 1'b0;

  always #5 clock = ~clock;

  regfile_scoreboard #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .EXT_REG(25), .ZERO_REG(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ext_en(ext_en), .ext_data(ext_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .last_wr(last_wr)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'd0;
    if (ext_en && a == 5'd25) return ext_data;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 5'd0) return 1'b0;
    return m_busy[a] && !(wb_en && wb_addr == a);
  endfunction

  // Model: architectural state after each edge.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] <= 32'd0;
        m_busy[i] <= 1'b0;
      end
      m_last      <= 32'd0;
      model_valid <= 1'b1;
    end else begin
      if (wb_en && wb_addr != 5'd0) begin
        m_regs[wb_addr] <= wb_data;
        m_busy[wb_addr] <= 1'b0;
        m_last          <= wb_data;
      end
      if (ext_en) m_regs[25] <= ext_data;
      if (issue_en && issue_addr != 5'd0) m_busy[issue_addr] <= 1'b1;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clock) begin
    if (model_valid) begin
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        check($sformatf("model rd_data%0d a=%0d", p, a), 64'(unpack_data2(rd_data, p)), 64'(exp_rd(a)));
        check($sformatf("model rd_busy%0d a=%0d", p, a), 64'(rd_busy[p]), 64'(exp_busy(a)));
      end
      check("model last_wr", 64'(last_wr), 64'(m_last));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    ext_en = 1'b0; ext_data = 32'd0;
    issue_en = 1'b0; issue_addr = 5'd0;
  endtask

  initial begin
    idle();
    rd_addr = pack_addr2(5'd0, 5'd0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state across every address
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = pack_addr2(AW'(a), AW'(31 - a));
      @(negedge clock);
      check("reset rd_data0", 64'(unpack_data2(rd_data, 0)), 64'd0);
      check("reset rd_data1", 64'(unpack_data2(rd_data, 1)), 64'd0);
      check("reset rd_busy", 64'(rd_busy), 64'd0);
      check("reset last_wr", 64'(last_wr), 64'd0);
      tick();
    end

    // Write-back bypass then stored value
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h12345678;
    rd_addr = pack_addr2(5'd8, 5'd0);
    @(negedge clock);
    check("wb bypass r8", 64'(unpack_data2(rd_data, 0)), 64'h12345678);
    tick(); idle();
    @(negedge clock);
    check("stored r8", 64'(unpack_data2(rd_data, 0)), 64'h12345678);
    check("last_wr after wb8", 64'(last_wr), 64'h12345678);
    tick();

    // Register 0 hardwired
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rd_addr = pack_addr2(5'd0, 5'd0);
    tick(); idle();
    issue_en = 1'b1; issue_addr = 5'd0;
    tick(); idle();
    @(negedge clock);
    check("r0 data", 64'(unpack_data2(rd_data, 0)), 64'd0);
    check("r0 busy", 64'(rd_busy), 64'd0);
    check("last_wr after wb0", 64'(last_wr), 64'h12345678);
    tick();

    // ext beats wb on register 25; last_wr still takes wb data
    ext_en = 1'b1; ext_data = 32'hAAAA0000;
    wb_en = 1'b1; wb_addr = 5'd25; wb_data = 32'h00005555;
    rd_addr = pack_addr2(5'd25, 5'd8);
    @(negedge clock);
    check("ext bypass r25", 64'(unpack_data2(rd_data, 0)), 64'hAAAA0000);
    tick(); idle();
    @(negedge clock);
    check("stored r25", 64'(unpack_data2(rd_data, 0)), 64'hAAAA0000);
    check("last_wr wb25", 64'(last_wr), 64'h00005555);
    tick();
    ext_en = 1'b1; ext_data = 32'h00001111;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000099;
    tick(); idle();
    rd_addr = pack_addr2(5'd9, 5'd25);
    @(negedge clock);
    check("dual write r9", 64'(unpack_data2(rd_data, 0)), 64'h00000099);
    check("dual write r25", 64'(unpack_data2(rd_data, 1)), 64'h00001111);
    check("last_wr wb9", 64'(last_wr), 64'h00000099);
    tick();

    // Load-use hazard on register 9
    issue_en = 1'b1; issue_addr = 5'd9;
    tick(); idle();
    rd_addr = pack_addr2(5'd9, 5'd9);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("busy r9 pending", 64'(rd_busy), 64'd3);
      tick();
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000BEEF;
    @(negedge clock);
    check("busy r9 wb cycle", 64'(rd_busy), 64'd0);
    check("data r9 wb cycle", 64'(unpack_data2(rd_data, 0)), 64'h0000BEEF);
    tick(); idle();
    @(negedge clock);
    check("busy r9 cleared", 64'(rd_busy), 64'd0);
    check("data r9 stored", 64'(unpack_data2(rd_data, 1)), 64'h0000BEEF);
    tick();

    // Issue supersedes same-cycle wb; then reset drops everything
    issue_en = 1'b1; issue_addr = 5'd10;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h00000010;
    tick(); idle();
    issue_en = 1'b1; issue_addr = 5'd11;
    rd_addr = pack_addr2(5'd10, 5'd9);
    @(negedge clock);
    check("busy r10 kept", 64'(rd_busy), 64'd1);
    check("data r10", 64'(unpack_data2(rd_data, 0)), 64'h00000010);
    tick(); idle();
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h0000DEAD;
    issue_en = 1'b1; issue_addr = 5'd12;
    tick(); idle();
    reset = 1'b0;
    rd_addr = pack_addr2(5'd10, 5'd11);
    @(negedge clock);
    check("post-reset busy", 64'(rd_busy), 64'd0);
    check("post-reset r10", 64'(unpack_data2(rd_data, 0)), 64'd0);
    check("post-reset last_wr", 64'(last_wr), 64'd0);
    tick();
    rd_addr = pack_addr2(5'd12, 5'd25);
    @(negedge clock);
    check("post-reset r12", 64'(unpack_data2(rd_data, 0)), 64'd0);
    check("post-reset r25", 64'(unpack_data2(rd_data, 1)), 64'd0);
    check("post-reset busy12", 64'(rd_busy), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
